stream_burst_arbiter: RTL and testbench
=======================================

// Module: stream_burst_arbiter
// PURPOSE
//  Shares one stb/ack write port, typically the input of the 64-deep sample FIFO, between N_REQ producers.
//  Grants whole bursts of BURST beats (one 8-sample DCT row by default); holds the grant until the burst completes.
//  Sits between the per-channel sample sources and the FIFO feeding the DCT datapath.
//  Round-robin fairness between requesters; a stall watchdog frees the port if a granted producer stops.
// PARAMETERS
//  N_REQ      4   number of requesters (>=2)
//  WIDTH      8   data width per beat
//  BURST      8   beats per grant (>=1)
//  STALL_MAX  16  consecutive no-beat cycles in a burst before abort (>=1)
// PORTS
//  CLK        in   1              single clock, all logic on posedge
//  RST_N      in   1              synchronous active-low reset
//  req_data   in   N_REQ*WIDTH    requester k data at [k*WIDTH +: WIDTH]
//  req_stb    in   N_REQ          requester k has a valid beat
//  req_ack    out  N_REQ          beat of requester k accepted this cycle
//  o_data     out  WIDTH          data to FIFO i_data
//  o_stb      out  1              to FIFO i_stb
//  o_ack      in   1              from FIFO i_ack (combinational, already includes stb & !full)
//  o_last     out  1              current beat is the last of the burst
//  o_grant    out  $clog2(N_REQ)  index of the granted requester (valid while o_busy)
//  o_busy     out  1              burst in progress
//  o_abort    out  1              one-cycle pulse: burst aborted by the watchdog
// BEHAVIOUR
//  Beat = o_stb & o_ack in the same cycle. FSM states: IDLE, BURST.
//  Reset (RST_N low at posedge): state=IDLE, rr pointer=0, grant=0, beat count=0, stall count=0.
//   Outputs: req_ack=0, o_stb=0, o_last=0, o_busy=0, o_abort=0, o_grant=0, o_data=0.
//   Reset wins over every other event, including a pending beat mid-burst.
//  IDLE:
//   o_stb=0; no beats are transferred.
//   If any req_stb is high, pick the first asserted index scanning ptr, ptr+1, ..., mod N_REQ.
//   Register that index into grant; go to BURST next cycle. Arbitration latency is 1 cycle.
//  BURST, combinational path:
//   o_stb=req_stb[grant]; o_data=req_data[grant]; req_ack[grant]=o_ack; all other req_ack=0.
//   o_stb never depends on o_ack, so no combinational loop exists.
//  BURST, beat counting:
//   beat count increments on each beat.
//   o_last = o_stb & (beat count == BURST-1).
//   A beat with o_last set -> IDLE; ptr <= (grant+1) mod N_REQ; beat count <= 0.
//   Next grant at the earliest 1 cycle later. Back-to-back bursts therefore leave one idle cycle.
//  BURST, stall watchdog:
//   stall count increments on each BURST cycle with no beat and resets to 0 on a beat.
//   Two stall causes are counted identically: FIFO full (o_ack=0) and the requester dropping stb.
//   When stall count reaches STALL_MAX-1 and that cycle also has no beat:
//    go to IDLE; ptr <= grant+1; beat count <= 0; o_abort pulses for 1 cycle (registered).
//  Other requesters' stb changes during BURST are ignored; the grant is never pre-empted.
//  Requesters must hold stb and data until acked. The arbiter does not buffer data.
//  ptr wraps N_REQ-1 -> 0. Counter widths are $clog2(BURST+1) and $clog2(STALL_MAX+1).
//  o_busy = (state==BURST). o_grant is registered and holds its last value in IDLE.
// STRUCTURE
//  Shared package dct_stream_pkg holds:
//   the FSM state localparams (ST_IDLE=1'b0, ST_BURST=1'b1);
//   the defaults DCT_ROW_LEN=8 and DCT_BLK_LEN=64, reused by the FIFO and DCT sequencers.
//  One sub-module, rr_priority_pick #(N): combinational.
//   Inputs req[N] and ptr; outputs found and idx, the first set bit at or after ptr, wrapping.
//  Top module keeps the FSM, counters and output muxing.
// TESTING
//  1. Only req0 stb, 8 beats, o_ack=1:
//     grant=0 on cycle 1; beats on cycles 1-8; o_last on beat 8; IDLE on cycle 9; ptr=1.
//  2. req1 and req3 both stb continuously, ptr=0:
//     grant order 1,3,1,3; exactly 8 beats each; 1 idle cycle between bursts.
//  3. FIFO full (o_ack=0) for 5 cycles mid-burst:
//     no req_ack during the stall; burst resumes; total 8 beats; data order preserved; no abort.
//  4. req2 drops stb after beat 3 with STALL_MAX=16:
//     o_abort pulses 1 cycle after the 16th stall cycle; state IDLE; ptr=3; beat count=0.
//  5. RST_N low during beat 5 of a burst:
//     next cycle all outputs at reset values; ptr=0; next grant is recomputed from req0.
//  6. ptr=3, all four stb high:
//     grant=3, then 0 (wrap); each burst is exactly BURST beats.

Source files
------------

// File: rtl/dct_stream_pkg.sv
// Shared definitions for the DCT sample-stream blocks.
//   arb_state_t  : burst arbiter FSM encoding (ST_IDLE=0, ST_BURST=1)
//   DCT_ROW_LEN  : samples per DCT row, default burst length
//   DCT_BLK_LEN  : samples per 8x8 DCT block, default FIFO depth
package dct_stream_pkg;

   localparam int DCT_ROW_LEN = 8;
   localparam int DCT_BLK_LEN = 64;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker (purely combinational).
// Finds the first set bit of req scanning ptr, ptr+1, ..., wrapping at N-1.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  index where the scan starts (highest priority)
//   found out 1   at least one request is set
//   idx   out IW  index of the winning request (0 when none found)
module rr_priority_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   localparam int SW = IW + 1;

   logic [SW-1:0] pos;

   // Scan offsets from the far end back towards ptr so the closest
   // requester (smallest offset) is the last, and therefore winning, write.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int off = N - 1; off >= 0; off--) begin
         pos = {1'b0, ptr} + SW'(off);
         if (pos >= SW'(N)) begin
            pos = pos - SW'(N);
         end
         if (req[pos[IW-1:0]]) begin
            found = 1'b1;
            idx   = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/stream_burst_arbiter.sv
// Burst arbiter sharing one stb/ack write port (normally the sample FIFO
// input) between N_REQ producers. Each grant covers BURST beats and is held
// until the burst completes; fairness is round-robin. A watchdog aborts a
// burst after STALL_MAX consecutive cycles without a beat.
// Ports:
//   CLK      in  1              clock, all logic on posedge
//   RST_N    in  1              synchronous active-low reset
//   req_data in  N_REQ*WIDTH    requester k data at [k*WIDTH +: WIDTH]
//   req_stb  in  N_REQ          requester k has a valid beat
//   req_ack  out N_REQ          beat of requester k accepted this cycle
//   o_data   out WIDTH          data towards the FIFO
//   o_stb    out 1              strobe towards the FIFO
//   o_ack    in  1              FIFO accept (already includes stb & !full)
//   o_last   out 1              current beat is the last of the burst
//   o_grant  out $clog2(N_REQ)  granted requester index (valid while o_busy)
//   o_busy   out 1              burst in progress
//   o_abort  out 1              one-cycle pulse: burst aborted by watchdog
module stream_burst_arbiter
   import dct_stream_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 8,
   parameter int BURST     = DCT_ROW_LEN,
   parameter int STALL_MAX = 16
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
   input  logic [N_REQ-1:0]         req_stb,
   output logic [N_REQ-1:0]         req_ack,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_stb,
   input  logic                     o_ack,
   output logic                     o_last,
   output logic [$clog2(N_REQ)-1:0] o_grant,
   output logic                     o_busy,
   output logic                     o_abort
);

   localparam int GW = $clog2(N_REQ);
   localparam int BW = $clog2(BURST + 1);
   localparam int SW = $clog2(STALL_MAX + 1);

   localparam logic [BW-1:0] LAST_BEAT  = BW'(BURST - 1);
   localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

   arb_state_t    state, state_nxt;
   logic [GW-1:0] grant, grant_nxt;
   logic [GW-1:0] ptr, ptr_nxt;
   logic [BW-1:0] beat_cnt, beat_nxt;
   logic [SW-1:0] stall_cnt, stall_nxt;
   logic          abort_r, abort_nxt;
   logic          beat;
   logic          pick_found;
   logic [GW-1:0] pick_idx;

   // Round-robin successor of a requester index.
   function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] g);
      if (g == GW'(N_REQ - 1)) begin
         return '0;
      end
      return g + 1'b1;
   endfunction

   rr_priority_pick #(
      .N  (N_REQ),
      .IW (GW)
   ) u_pick (
      .req   (req_stb),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         grant     <= '0;
         ptr       <= '0;
         beat_cnt  <= '0;
         stall_cnt <= '0;
         abort_r   <= 1'b0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         ptr       <= ptr_nxt;
         beat_cnt  <= beat_nxt;
         stall_cnt <= stall_nxt;
         abort_r   <= abort_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      ptr_nxt   = ptr;
      beat_nxt  = beat_cnt;
      stall_nxt = stall_cnt;
      abort_nxt = 1'b0;
      o_stb     = 1'b0;
      o_data    = '0;
      req_ack   = '0;
      o_last    = 1'b0;
      beat      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (pick_found) begin
               grant_nxt = pick_idx;
               beat_nxt  = '0;
               stall_nxt = '0;
               state_nxt = ST_BURST;
            end
         end

         ST_BURST: begin
            // o_stb is taken from the requester only, never from o_ack,
            // so the FIFO may close the loop combinationally on its side.
            for (int k = 0; k < N_REQ; k++) begin
               if (grant == GW'(k)) begin
                  o_stb      = req_stb[k];
                  o_data     = req_data[k*WIDTH +: WIDTH];
                  req_ack[k] = o_ack;
               end
            end
            o_last = o_stb & (beat_cnt == LAST_BEAT);
            beat   = o_stb & o_ack;

            if (beat) begin
               stall_nxt = '0;
               if (o_last) begin
                  state_nxt = ST_IDLE;
                  ptr_nxt   = next_idx(grant);
                  beat_nxt  = '0;
               end else begin
                  beat_nxt = beat_cnt + 1'b1;
               end
            end else if (stall_cnt == STALL_LAST) begin
               // FIFO-full and dropped-stb stalls are treated alike.
               state_nxt = ST_IDLE;
               ptr_nxt   = next_idx(grant);
               beat_nxt  = '0;
               stall_nxt = '0;
               abort_nxt = 1'b1;
            end else begin
               stall_nxt = stall_cnt + 1'b1;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   assign o_busy  = (state == ST_BURST);
   assign o_grant = grant;
   assign o_abort = abort_r;

endmodule

// File: tb/tb_stream_burst_arbiter.sv
module tb_stream_burst_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int BL = 8;
   localparam int SM = 16;

   logic           CLK;
   logic           RST_N;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_stb;
   logic [N-1:0]   req_ack;
   logic [W-1:0]   o_data;
   logic           o_stb;
   logic           o_ack;
   logic           o_last;
   logic [1:0]     o_grant;
   logic           o_busy;
   logic           o_abort;

   // FIFO model: accepts whenever strobed and not full.
   logic full;
   assign o_ack = o_stb & ~full;

   stream_burst_arbiter #(
      .N_REQ(N), .WIDTH(W), .BURST(BL), .STALL_MAX(SM)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .req_data(req_data), .req_stb(req_stb),
      .req_ack(req_ack), .o_data(o_data), .o_stb(o_stb), .o_ack(o_ack),
      .o_last(o_last), .o_grant(o_grant), .o_busy(o_busy), .o_abort(o_abort)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int checks = 0;
   int errors = 0;

   // Producer-side queues (what each requester still has to send) and
   // scoreboard queues (what the FIFO must receive from each requester).
   logic [W-1:0] src_q[N][$];
   logic [W-1:0] exp_q[N][$];
   bit           hold[N];
   int           acked[N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input int k, input int n);
      logic [W-1:0] d;
      for (int i = 0; i < n; i++) begin
         d = W'($urandom);
         src_q[k].push_back(d);
         exp_q[k].push_back(d);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         if (src_q[k].size() > 0 && !hold[k]) begin
            req_stb[k]          = 1'b1;
            req_data[k*W +: W]  = src_q[k][0];
         end else begin
            req_stb[k]          = 1'b0;
            req_data[k*W +: W]  = W'($urandom);
         end
      end
   endtask

   task automatic cycle();
      logic [N-1:0] snap;
      logic         rs;
      drive();
      @(negedge CLK);
      snap = req_ack;
      rs   = RST_N;
      @(posedge CLK);
      #1;
      for (int k = 0; k < N; k++) begin
         if (rs && snap[k]) begin
            void'(src_q[k].pop_front());
            acked[k]++;
         end
      end
   endtask

   function automatic bit pending();
      for (int k = 0; k < N; k++) if (src_q[k].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain();
      int n = 0;
      while ((pending() || o_busy) && n < 3000) begin
         cycle();
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL drain_timeout: got busy=%0b expected idle after %0d cycles", o_busy, n);
      end
   endtask

   task automatic wait_acked(input int k, input int target);
      int n = 0;
      while (acked[k] < target && n < 300) begin
         cycle();
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL wait_ack%0d: got %0d expected %0d", k, acked[k], target);
      end
   endtask

   // ---------------- reference model + monitor ----------------
   // Behaviour expressed in terms of bursts: a burst grants the first
   // requester at/after the pointer, delivers BL beats, or is dropped after
   // SM consecutive beat-less cycles; the pointer then moves past the grant.
   bit m_busy, m_abort, started;
   int m_grant, m_ptr, m_beats, m_stall;

   initial begin
      bit           e_stb, e_beat;
      logic [N-1:0] e_ack;
      logic [W-1:0] e_dat;
      m_busy = 0; m_abort = 0; m_grant = 0; m_ptr = 0; m_beats = 0; m_stall = 0;
      started = 0;
      forever begin
         @(negedge CLK);
         e_stb  = m_busy && req_stb[m_grant];
         e_beat = e_stb && !full && RST_N;
         if (started) begin
            e_ack = (e_stb && !full) ? (N'(1) << m_grant) : '0;
            chk("busy",    32'(o_busy),  32'(m_busy));
            chk("grant",   32'(o_grant), 32'(m_grant));
            chk("abort",   32'(o_abort), 32'(m_abort));
            chk("stb",     32'(o_stb),   32'(e_stb));
            chk("last",    32'(o_last),  32'(e_stb && m_beats == BL - 1));
            chk("req_ack", 32'(req_ack), 32'(e_ack));
            if (!m_busy) chk("idle_data", 32'(o_data), 32'h0);
            if (e_beat) begin
               if (exp_q[m_grant].size() == 0) begin
                  chk("beat_unexpected", 32'(o_data), 32'hFFFF_FFFF);
               end else begin
                  e_dat = exp_q[m_grant].pop_front();
                  chk("data", 32'(o_data), 32'(e_dat));
               end
            end
         end
         if (!RST_N) begin
            m_busy = 0; m_abort = 0; m_grant = 0; m_ptr = 0; m_beats = 0; m_stall = 0;
            started = 1;
         end else if (started) begin
            m_abort = 0;
            if (!m_busy) begin
               for (int i = N - 1; i >= 0; i--) begin
                  if (req_stb[(m_ptr + i) % N]) begin
                     m_busy  = 1;
                     m_grant = (m_ptr + i) % N;
                  end
               end
               m_beats = 0;
               m_stall = 0;
            end else if (e_beat) begin
               m_stall = 0;
               m_beats++;
               if (m_beats == BL) begin
                  m_busy  = 0;
                  m_beats = 0;
                  m_ptr   = (m_grant + 1) % N;
               end
            end else begin
               m_stall++;
               if (m_stall == SM) begin
                  m_busy  = 0;
                  m_abort = 1;
                  m_beats = 0;
                  m_stall = 0;
                  m_ptr   = (m_grant + 1) % N;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      RST_N    = 1'b0;
      full     = 1'b0;
      req_stb  = '0;
      req_data = '0;
      for (int k = 0; k < N; k++) begin hold[k] = 0; acked[k] = 0; end
      repeat (3) cycle();
      RST_N = 1'b1;
      cycle();

      // Single requester, uninterrupted burst.
      add(0, 8);
      drain();

      // Two requesters alternating.
      add(1, 16);
      add(3, 16);
      drain();

      // FIFO full for 5 cycles mid-burst.
      for (int k = 0; k < N; k++) acked[k] = 0;
      add(2, 8);
      wait_acked(2, 2);
      full = 1'b1;
      repeat (5) cycle();
      full = 1'b0;
      drain();

      // Requester drops stb after 3 beats: watchdog abort.
      for (int k = 0; k < N; k++) acked[k] = 0;
      add(2, 8);
      wait_acked(2, 3);
      hold[2] = 1;
      repeat (24) cycle();
      hold[2] = 0;
      drain();

      // Reset during beat 5.
      for (int k = 0; k < N; k++) acked[k] = 0;
      add(0, 8);
      wait_acked(0, 4);
      RST_N = 1'b0;
      cycle();
      RST_N = 1'b1;
      drain();

      // Leave the pointer at 3, then all four requesters at once.
      add(2, 8);
      drain();
      for (int k = 0; k < N; k++) add(k, 8);
      drain();

      // Random traffic with FIFO back-pressure and stb drops.
      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            int k;
            k = $urandom_range(0, N - 1);
            if (src_q[k].size() < 24) add(k, $urandom_range(1, 12));
         end
         full = ($urandom_range(0, 3) == 0);
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 149) == 0) hold[k] = !hold[k];
         end
         cycle();
      end
      full = 1'b0;
      for (int k = 0; k < N; k++) hold[k] = 0;
      drain();
      repeat (2) cycle();

      for (int k = 0; k < N; k++) begin
         chk("left_over", 32'(exp_q[k].size()), 32'(src_q[k].size()));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
